bcd_accumulator: RTL and testbench

Parametrised sequential BCD accumulator for the DE10 lab designs. It generalises the fixed two-digit combinational BCD adder to N digits, adds a subtract mode, and processes one digit per clock with a start/busy/done handshake. Every digit drives a 7-segment display with leading-zero blanking. It sits between the switch/operand logic and the HEX outputs of the top level.

---
 rtl/bcd_accumulator_if.sv | 35 +++
 rtl/bcd_accumulator.sv | 219 +++++++++++++++++++++
 tb/tb_bcd_accumulator.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bcd_accumulator_if.sv
// +----------------------------------------------------------------------------+
// | Module   : bcd_accumulator_if                                              |
// | Brief    : Request/result bundle between operand logic and the BCD         |
// |            accumulator, with driver (master) and accumulator (slave) views.|
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

interface bcd_accumulator_if #(
  parameter int DIGITS = 4
);
  logic                  i_start;
  logic                  i_load;
  logic                  i_op;
  logic [4*DIGITS-1:0]   i_operand;
  logic                  o_busy;
  logic                  o_done;
  logic [4*DIGITS-1:0]   o_acc;
  logic                  o_carry;
  logic                  o_err;
  logic [8*DIGITS-1:0]   o_seg;

  modport master (
    output i_start, i_load, i_op, i_operand,
    input  o_busy, o_done, o_acc, o_carry, o_err, o_seg
  );

  modport slave (
    input  i_start, i_load, i_op, i_operand,
    output o_busy, o_done, o_acc, o_carry, o_err, o_seg
  );
endinterface

`default_nettype wire

// File: rtl/bcd_accumulator.sv
// +----------------------------------------------------------------------------+
// | Module   : bcd_accumulator                                                 |
// | Brief    : N-digit sequential BCD add/subtract accumulator, one digit per  |
// |            clock, with registered leading-zero-blanked 7-segment outputs.  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module bcd_accumulator #(
  parameter int DIGITS        = 4,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  bcd_accumulator_if.slave   bus
);

  localparam int W     = 4 * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  function automatic logic operand_valid(input logic [W-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (v[4*k +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  // Scan from the MSD down; a digit is blank until a nonzero digit has been seen.
  function automatic logic [8*DIGITS-1:0] seg_encode(input logic [W-1:0] v);
    logic [8*DIGITS-1:0] s;
    logic                nz;
    s  = '0;
    nz = 1'b0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      nz = nz | (v[4*k +: 4] != 4'd0);
      if (BLANK_LEADING && !nz && (k != 0)) s[8*k +: 8] = 8'hFF;
      else                                  s[8*k +: 8] = {1'b1, seg7(v[4*k +: 4])};
    end
    return s;
  endfunction

  logic [1:0]          state_q, state_d;
  logic [W-1:0]        acc_q, acc_d;
  logic                carry_q, carry_d;
  logic                err_q, err_d;
  logic                done_q, done_d;
  logic [8*DIGITS-1:0] seg_q, seg_d;
  logic [W-1:0]        work_q, work_d;
  logic [W-1:0]        opnd_q, opnd_d;
  logic                op_q, op_d;
  logic                c_q, c_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                err_pend_q, err_pend_d;

  logic                w_valid;
  logic [3:0]          w_acc_dig;
  logic [3:0]          w_op_dig;
  logic [3:0]          w_b;
  logic [4:0]          w_s;
  logic                w_gt9;
  logic [3:0]          w_dig;
  logic [W-1:0]        w_work_upd;

  assign w_valid = operand_valid(bus.i_operand);

  always_ff @(posedge i_clk) begin : p_state_reg
    if (i_rst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin : p_next_state
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (bus.i_load)       state_d = S_DONE;
        else if (bus.i_start) state_d = w_valid ? S_RUN : S_DONE;
      end
      S_RUN:   if (idx_q == LAST_IDX) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin : p_fsm_out
    bus.o_busy = 1'b0;
    if (state_q != S_IDLE) bus.o_busy = 1'b1;
  end

  // Ten's complement subtract: b = 9 - op_k with the initial carry set to 1.
  always_comb begin : p_digit
    w_acc_dig  = '0;
    w_op_dig   = '0;
    w_work_upd = work_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        w_acc_dig = work_q[4*k +: 4];
        w_op_dig  = opnd_q[4*k +: 4];
      end
    end
    w_b   = op_q ? (4'd9 - w_op_dig) : w_op_dig;
    w_s   = {1'b0, w_acc_dig} + {1'b0, w_b} + {4'b0000, c_q};
    w_gt9 = (w_s > 5'd9);
    w_dig = w_gt9 ? 4'(w_s - 5'd10) : w_s[3:0];
    for (int k = 0; k < DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) w_work_upd[4*k +: 4] = w_dig;
    end
  end

  // Every path goes through DONE, which commits work/c/err_pend uniformly;
  // loads and rejects preload those registers so the commit is a no-op where needed.
  always_comb begin : p_datapath
    acc_d      = acc_q;
    carry_d    = carry_q;
    err_d      = err_q;
    done_d     = 1'b0;
    work_d     = work_q;
    opnd_d     = opnd_q;
    op_d       = op_q;
    c_d        = c_q;
    idx_d      = idx_q;
    err_pend_d = err_pend_q;
    case (state_q)
      S_IDLE: begin
        if (bus.i_load && w_valid) begin
          work_d     = bus.i_operand;
          c_d        = 1'b0;
          op_d       = 1'b0;
          err_pend_d = 1'b0;
        end else if (!bus.i_load && bus.i_start && w_valid) begin
          opnd_d     = bus.i_operand;
          op_d       = bus.i_op;
          work_d     = acc_q;
          idx_d      = '0;
          c_d        = bus.i_op;
          err_pend_d = 1'b0;
        end else if (bus.i_load || bus.i_start) begin
          work_d     = acc_q;
          c_d        = carry_q;
          op_d       = 1'b0;
          err_pend_d = 1'b1;
        end
      end
      S_RUN: begin
        work_d = w_work_upd;
        c_d    = w_gt9;
        idx_d  = idx_q + 1'b1;
      end
      S_DONE: begin
        acc_d   = work_q;
        carry_d = op_q ? ~c_q : c_q;
        err_d   = err_pend_q;
        done_d  = 1'b1;
      end
      default: ;
    endcase
    seg_d = seg_encode(acc_d);
  end

  always_ff @(posedge i_clk) begin : p_datapath_reg
    if (i_rst) begin
      acc_q      <= '0;
      carry_q    <= 1'b0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      seg_q      <= seg_encode('0);
      work_q     <= '0;
      opnd_q     <= '0;
      op_q       <= 1'b0;
      c_q        <= 1'b0;
      idx_q      <= '0;
      err_pend_q <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      carry_q    <= carry_d;
      err_q      <= err_d;
      done_q     <= done_d;
      seg_q      <= seg_d;
      work_q     <= work_d;
      opnd_q     <= opnd_d;
      op_q       <= op_d;
      c_q        <= c_d;
      idx_q      <= idx_d;
      err_pend_q <= err_pend_d;
    end
  end

  assign bus.o_done  = done_q;
  assign bus.o_acc   = acc_q;
  assign bus.o_carry = carry_q;
  assign bus.o_err   = err_q;
  assign bus.o_seg   = seg_q;

endmodule

`default_nettype wire

// File: tb/tb_bcd_accumulator.sv
// +----------------------------------------------------------------------------+
// | Module   : tb_bcd_accumulator                                              |
// | Brief    : Directed self-checking bench for bcd_accumulator (4, 1, 8 dig). |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_bcd_accumulator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst4 = 1'b1;
  logic rst1 = 1'b1;
  logic rst8 = 1'b1;

  int checks = 0;
  int errors = 0;

  bcd_accumulator_if #(.DIGITS(4)) if4 ();
  bcd_accumulator_if #(.DIGITS(1)) if1 ();
  bcd_accumulator_if #(.DIGITS(8)) if8 ();

  bcd_accumulator #(.DIGITS(4), .BLANK_LEADING(1'b1)) u_dut4 (.i_clk(clk), .i_rst(rst4), .bus(if4));
  bcd_accumulator #(.DIGITS(1), .BLANK_LEADING(1'b1)) u_dut1 (.i_clk(clk), .i_rst(rst1), .bus(if1));
  bcd_accumulator #(.DIGITS(8), .BLANK_LEADING(1'b0)) u_dut8 (.i_clk(clk), .i_rst(rst8), .bus(if8));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int which, input logic ld, input logic st,
                       input logic op, input logic [31:0] opd);
    case (which)
      4: begin if4.i_load = ld; if4.i_start = st; if4.i_op = op; if4.i_operand = opd[15:0]; end
      1: begin if1.i_load = ld; if1.i_start = st; if1.i_op = op; if1.i_operand = opd[3:0];  end
      default: begin if8.i_load = ld; if8.i_start = st; if8.i_op = op; if8.i_operand = opd; end
    endcase
  endtask

  // One-cycle request; returns 1 ns after the sampling edge.
  task automatic pulse(input int which, input logic ld, input logic st,
                       input logic op, input logic [31:0] opd);
    drive(which, ld, st, op, opd);
    @(posedge clk);
    #1;
    drive(which, 1'b0, 1'b0, op, opd);
  endtask

  task automatic wait_done(input int which, input int max_cyc, output int cyc);
    logic seen;
    seen = 1'b0;
    cyc  = 0;
    while (!seen && cyc < max_cyc) begin
      @(posedge clk);
      #1;
      cyc++;
      case (which)
        4:       seen = if4.o_done;
        1:       seen = if1.o_done;
        default: seen = if8.o_done;
      endcase
    end
    if (!seen) cyc = -1;
  endtask

  int lat;
  int dcount;
  int first;

  initial begin
    drive(4, 1'b0, 1'b0, 1'b0, 32'h0);
    drive(1, 1'b0, 1'b0, 1'b0, 32'h0);
    drive(8, 1'b0, 1'b0, 1'b0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst4_acc",   64'(if4.o_acc),   64'h0);
    chk("rst4_carry", 64'(if4.o_carry), 64'h0);
    chk("rst4_err",   64'(if4.o_err),   64'h0);
    chk("rst4_busy",  64'(if4.o_busy),  64'h0);
    chk("rst4_done",  64'(if4.o_done),  64'h0);
    chk("rst4_seg",   64'(if4.o_seg),   64'hFFFF_FFC0);
    chk("rst1_seg",   64'(if1.o_seg),   64'hC0);
    chk("rst8_seg",   64'(if8.o_seg),   64'hC0C0_C0C0_C0C0_C0C0);
    chk("rst8_acc",   64'(if8.o_acc),   64'h0);
    rst4 = 1'b0;
    rst1 = 1'b0;
    rst8 = 1'b0;

    // 0347 + 0256 = 0603
    pulse(4, 1'b1, 1'b0, 1'b0, 32'h0347);
    chk("load_busy", 64'(if4.o_busy), 64'h1);
    wait_done(4, 20, lat);
    chk("load_lat", 64'(lat), 64'd1);
    chk("load_acc", 64'(if4.o_acc), 64'h0347);
    pulse(4, 1'b0, 1'b1, 1'b0, 32'h0256);
    chk("add_busy", 64'(if4.o_busy), 64'h1);
    wait_done(4, 20, lat);
    chk("add_lat",   64'(lat), 64'd5);
    chk("add_acc",   64'(if4.o_acc), 64'h0603);
    chk("add_carry", 64'(if4.o_carry), 64'h0);
    chk("add_seg",   64'(if4.o_seg), 64'hFF82_C0B0);
    chk("add_busy_end", 64'(if4.o_busy), 64'h0);
    @(posedge clk);
    #1;
    chk("done_pulse_width", 64'(if4.o_done), 64'h0);

    // 9999 + 0001 overflows
    pulse(4, 1'b1, 1'b0, 1'b0, 32'h9999);
    wait_done(4, 20, lat);
    pulse(4, 1'b0, 1'b1, 1'b0, 32'h0001);
    wait_done(4, 20, lat);
    chk("ovf_acc",   64'(if4.o_acc), 64'h0000);
    chk("ovf_carry", 64'(if4.o_carry), 64'h1);
    chk("ovf_seg",   64'(if4.o_seg), 64'hFFFF_FFC0);

    // 0100 - 0001 = 0099, no borrow
    pulse(4, 1'b1, 1'b0, 1'b0, 32'h0100);
    wait_done(4, 20, lat);
    pulse(4, 1'b0, 1'b1, 1'b1, 32'h0001);
    wait_done(4, 20, lat);
    chk("sub_acc",   64'(if4.o_acc), 64'h0099);
    chk("sub_carry", 64'(if4.o_carry), 64'h0);
    chk("sub_seg",   64'(if4.o_seg), 64'hFFFF_9090);

    // 0000 - 0001 wraps to 9999 with borrow
    pulse(4, 1'b1, 1'b0, 1'b0, 32'h0000);
    wait_done(4, 20, lat);
    pulse(4, 1'b0, 1'b1, 1'b1, 32'h0001);
    wait_done(4, 20, lat);
    chk("wrap_acc",   64'(if4.o_acc), 64'h9999);
    chk("wrap_carry", 64'(if4.o_carry), 64'h1);
    chk("wrap_seg",   64'(if4.o_seg), 64'h9090_9090);

    // Invalid operand rejected, then cleared by a valid start
    pulse(4, 1'b1, 1'b0, 1'b0, 32'h0042);
    wait_done(4, 20, lat);
    pulse(4, 1'b0, 1'b1, 1'b0, 32'h00A5);
    wait_done(4, 20, lat);
    chk("inv_lat",   64'(lat), 64'd1);
    chk("inv_err",   64'(if4.o_err), 64'h1);
    chk("inv_acc",   64'(if4.o_acc), 64'h0042);
    chk("inv_carry", 64'(if4.o_carry), 64'h0);
    pulse(4, 1'b0, 1'b1, 1'b0, 32'h0001);
    wait_done(4, 20, lat);
    chk("clr_lat", 64'(lat), 64'd5);
    chk("clr_err", 64'(if4.o_err), 64'h0);
    chk("clr_acc", 64'(if4.o_acc), 64'h0043);

    // Requests and operand changes while busy are ignored
    dcount = 0;
    first  = -1;
    pulse(4, 1'b0, 1'b1, 1'b0, 32'h0010);
    drive(4, 1'b1, 1'b1, 1'b1, 32'h5A5A);
    @(posedge clk);
    #1;
    if (if4.o_done) dcount++;
    drive(4, 1'b0, 1'b1, 1'b1, 32'hA5A5);
    @(posedge clk);
    #1;
    if (if4.o_done) dcount++;
    drive(4, 1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 3; i <= 12; i++) begin
      @(posedge clk);
      #1;
      if (if4.o_done) begin
        dcount++;
        if (first < 0) first = i;
      end
    end
    chk("busy_done_count", 64'(dcount), 64'd1);
    chk("busy_done_at",    64'(first), 64'd5);
    chk("busy_acc",        64'(if4.o_acc), 64'h0053);
    chk("busy_carry",      64'(if4.o_carry), 64'h0);

    // Reset during the third RUN cycle aborts silently
    pulse(4, 1'b0, 1'b1, 1'b0, 32'h0001);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst4 = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_busy", 64'(if4.o_busy), 64'h0);
    chk("abort_acc",  64'(if4.o_acc), 64'h0);
    chk("abort_done", 64'(if4.o_done), 64'h0);
    chk("abort_seg",  64'(if4.o_seg), 64'hFFFF_FFC0);
    rst4 = 1'b0;
    dcount = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (if4.o_done) dcount++;
    end
    chk("abort_no_done", 64'(dcount), 64'd0);

    // Single digit: 9 + 1
    pulse(1, 1'b1, 1'b0, 1'b0, 32'h9);
    wait_done(1, 20, lat);
    pulse(1, 1'b0, 1'b1, 1'b0, 32'h1);
    wait_done(1, 20, lat);
    chk("d1_lat",   64'(lat), 64'd2);
    chk("d1_acc",   64'(if1.o_acc), 64'h0);
    chk("d1_carry", 64'(if1.o_carry), 64'h1);
    chk("d1_seg",   64'(if1.o_seg), 64'hC0);

    // Eight digits, no blanking: 99999999 + 1
    pulse(8, 1'b1, 1'b0, 1'b0, 32'h9999_9999);
    wait_done(8, 20, lat);
    pulse(8, 1'b0, 1'b1, 1'b0, 32'h0000_0001);
    wait_done(8, 20, lat);
    chk("d8_lat",   64'(lat), 64'd9);
    chk("d8_acc",   64'(if8.o_acc), 64'h0);
    chk("d8_carry", 64'(if8.o_carry), 64'h1);
    chk("d8_seg",   64'(if8.o_seg), 64'hC0C0_C0C0_C0C0_C0C0);

    pulse(8, 1'b1, 1'b0, 1'b0, 32'h0000_0012);
    wait_done(8, 20, lat);
    pulse(8, 1'b0, 1'b1, 1'b0, 32'h0000_0005);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst8 = 1'b1;
    @(posedge clk);
    #1;
    chk("d8_abort_busy", 64'(if8.o_busy), 64'h0);
    chk("d8_abort_acc",  64'(if8.o_acc), 64'h0);
    rst8 = 1'b0;
    dcount = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (if8.o_done) dcount++;
    end
    chk("d8_abort_no_done", 64'(dcount), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
